// File: rtl/axis_dest_switch_pkg.sv
// Shared types and constants for the destination switch behind the packet filter.
package axis_dest_switch_pkg;

  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 16;
  localparam int DEST_W    = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sw_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [DEST_W-1:0] tdest;
    logic              tlast;
    logic              tvalid;
  } axis_dest_src_t;

  typedef struct packed {
    logic tready;
  } axis_dest_snk_t;

endpackage

// File: rtl/axis_rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last_i+1, wrapping.
module axis_rr_arbiter
  import axis_dest_switch_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [DEST_W-1:0]    last_i,
  output logic [DEST_W-1:0]    winner_o,
  output logic                 found_o
);

  logic [DEST_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = '0;
    // k == NUM_PORTS wraps back to last_i itself, so it is searched last
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = last_i + DEST_W'(k);
      if (!found_o && req_i[idx]) begin
        winner_o = idx;
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_dest_switch.sv
// 4x4 packet-atomic AXI-Stream crossbar routing on first-beat tdest.
// Optional AXIS_DEST_SWITCH_OUT_REG_EN adds a 2-entry registered skid buffer per output.
//
//   state | meaning
//   IDLE  | no packet owns this output; arbitrate among requesting inputs
//   BUSY  | grant_q owns this output until its tlast beat is accepted
module axis_dest_switch
  import axis_dest_switch_pkg::sw_state_t, axis_dest_switch_pkg::IDLE,
         axis_dest_switch_pkg::BUSY, axis_dest_switch_pkg::axis_dest_src_t,
         axis_dest_switch_pkg::axis_dest_snk_t;
#(
  parameter int NUM_PORTS = axis_dest_switch_pkg::NUM_PORTS,
  parameter int DATA_W    = axis_dest_switch_pkg::DATA_W,
  parameter int DEST_W    = axis_dest_switch_pkg::DEST_W
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  in_tdata,
  input  logic [NUM_PORTS-1:0][DEST_W-1:0]  in_tdest,
  input  logic [NUM_PORTS-1:0]              in_tlast,
  input  logic [NUM_PORTS-1:0]              in_tvalid,
  output logic [NUM_PORTS-1:0]              in_tready,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  out_tdata,
  output logic [NUM_PORTS-1:0]              out_tlast,
  output logic [NUM_PORTS-1:0]              out_tvalid,
  input  logic [NUM_PORTS-1:0]              out_tready
);

  axis_dest_src_t src [NUM_PORTS];
  axis_dest_snk_t snk [NUM_PORTS];

  logic [NUM_PORTS-1:0]             busy;
  logic [NUM_PORTS-1:0]             granted;
  logic [NUM_PORTS-1:0]             up_ready;
  logic [NUM_PORTS-1:0][DEST_W-1:0] grant;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      src[i].tdata  = in_tdata[i];
      src[i].tdest  = in_tdest[i];
      src[i].tlast  = in_tlast[i];
      src[i].tvalid = in_tvalid[i];
    end
  end

  always_comb begin
    granted = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      snk[i].tready = 1'b0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (busy[o] && (grant[o] == DEST_W'(i))) begin
          granted[i]    = 1'b1;
          snk[i].tready = up_ready[o];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_tready[i] = snk[i].tready;
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    sw_state_t            state_q, state_d;
    logic [DEST_W-1:0]    grant_q, grant_d;
    logic [DEST_W-1:0]    last_q, last_d;
    logic [DEST_W-1:0]    win;
    logic                 found;
    logic [NUM_PORTS-1:0] req;
    logic                 up_valid, up_last, pkt_end;
    logic [DATA_W-1:0]    up_data;

    always_comb begin
      req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[i] = src[i].tvalid && (src[i].tdest == DEST_W'(o)) && !granted[i];
      end
    end

    axis_rr_arbiter u_arb (
      .req_i    (req),
      .last_i   (last_q),
      .winner_o (win),
      .found_o  (found)
    );

    assign up_valid = (state_q == BUSY) && src[grant_q].tvalid;
    assign up_last  = (state_q == BUSY) && src[grant_q].tlast;
    assign up_data  = (state_q == BUSY) ? src[grant_q].tdata : '0;
    assign pkt_end  = up_valid && up_ready[o] && up_last;

    always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_d = win;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (pkt_end) begin
            last_d  = grant_q;
            state_d = IDLE;
          end
        end
      endcase
    end

    // last_q resets to 3 so input 0 wins the first arbitration
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        grant_q <= '0;
        last_q  <= '1;
      end else begin
        state_q <= state_d;
        grant_q <= grant_d;
        last_q  <= last_d;
      end
    end

    assign busy[o]  = (state_q == BUSY);
    assign grant[o] = grant_q;

`ifdef AXIS_DEST_SWITCH_OUT_REG_EN
    logic              hd_v_q, hd_v_d, hd_l_q, hd_l_d;
    logic              tl_v_q, tl_v_d, tl_l_q, tl_l_d;
    logic [DATA_W-1:0] hd_dat_q, hd_dat_d, tl_dat_q, tl_dat_d;
    logic              push, pop;

    assign up_ready[o] = !tl_v_q;
    assign push        = up_valid && !tl_v_q;
    assign pop         = hd_v_q && out_tready[o];

    always_comb begin
      hd_v_d   = hd_v_q;
      hd_l_d   = hd_l_q;
      hd_dat_d = hd_dat_q;
      tl_v_d   = tl_v_q;
      tl_l_d   = tl_l_q;
      tl_dat_d = tl_dat_q;
      // push is impossible while the tail is occupied
      if (pop) begin
        if (tl_v_q) begin
          hd_l_d   = tl_l_q;
          hd_dat_d = tl_dat_q;
          tl_v_d   = 1'b0;
        end else if (push) begin
          hd_l_d   = up_last;
          hd_dat_d = up_data;
        end else begin
          hd_v_d = 1'b0;
        end
      end else if (push) begin
        if (!hd_v_q) begin
          hd_v_d   = 1'b1;
          hd_l_d   = up_last;
          hd_dat_d = up_data;
        end else begin
          tl_v_d   = 1'b1;
          tl_l_d   = up_last;
          tl_dat_d = up_data;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hd_v_q   <= 1'b0;
        hd_l_q   <= 1'b0;
        hd_dat_q <= '0;
        tl_v_q   <= 1'b0;
        tl_l_q   <= 1'b0;
        tl_dat_q <= '0;
      end else begin
        hd_v_q   <= hd_v_d;
        hd_l_q   <= hd_l_d;
        hd_dat_q <= hd_dat_d;
        tl_v_q   <= tl_v_d;
        tl_l_q   <= tl_l_d;
        tl_dat_q <= tl_dat_d;
      end
    end

    assign out_tvalid[o] = hd_v_q;
    assign out_tlast[o]  = hd_l_q;
    assign out_tdata[o]  = hd_dat_q;
`else
    assign up_ready[o]   = out_tready[o];
    assign out_tvalid[o] = up_valid;
    assign out_tlast[o]  = up_last;
    assign out_tdata[o]  = up_data;
`endif
  end

endmodule
